// File: rtl/cordic_phase_sequencer_pkg.sv
// Shared types and angle/sample constants for the CORDIC phase sequencer.
// The constants describe the 8-bit binary-angle format (0x80 = pi).
package cordic_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  localparam logic [7:0] ANGLE_PI   = 8'h80;
  // Top two angle bits 00 or 11 mean the angle is already in [-pi/2, pi/2).
  localparam logic [7:0] FOLD_MASK  = 8'hC0;
  localparam int         SAMPLE_MAX = 127;
  localparam int         SAMPLE_MIN = -128;

endpackage

// File: rtl/cordic_phase_sequencer_if.sv
// Start/done handshake between the phase sequencer (master) and the
// iterative CORDIC core (slave).
interface cordic_phase_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]        cordic_z_o;
  logic                         cordic_valid_strobe_o;
  logic signed [DATA_WIDTH-1:0] cordic_x_i;
  logic signed [DATA_WIDTH-1:0] cordic_y_i;
  logic                         cordic_valid_strobe_i;

  modport master (
    output cordic_z_o,
    output cordic_valid_strobe_o,
    input  cordic_x_i,
    input  cordic_y_i,
    input  cordic_valid_strobe_i
  );

  modport slave (
    input  cordic_z_o,
    input  cordic_valid_strobe_o,
    output cordic_x_i,
    output cordic_y_i,
    output cordic_valid_strobe_i
  );
endinterface

// File: rtl/cordic_quadrant_fold.sv
// Combinational quadrant fold of a phase into the CORDIC convergence range,
// plus the matching saturating negation that unfolds both result channels.
module cordic_quadrant_fold
  import cordic_phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]        phase_i,
  output logic [DATA_WIDTH-1:0]        angle_o,
  output logic                         flip_o,
  input  logic                         flip_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] y_i,
  output logic signed [DATA_WIDTH-1:0] x_o,
  output logic signed [DATA_WIDTH-1:0] y_o
);

  // Constants are defined for 8-bit words and scaled up for wider datapaths.
  localparam int SHIFT = DATA_WIDTH - 8;
  localparam logic [DATA_WIDTH-1:0]        PI_W   = DATA_WIDTH'(ANGLE_PI) << SHIFT;
  localparam logic [DATA_WIDTH-1:0]        MASK_W = DATA_WIDTH'(FOLD_MASK) << SHIFT;
  localparam logic signed [DATA_WIDTH-1:0] MIN_W  = DATA_WIDTH'(SAMPLE_MIN) << SHIFT;
  localparam logic signed [DATA_WIDTH-1:0] MAX_W  =
    (DATA_WIDTH'(SAMPLE_MAX) << SHIFT) | DATA_WIDTH'((1 << SHIFT) - 1);

  function automatic logic signed [DATA_WIDTH-1:0] neg_sat(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (v == MIN_W) return MAX_W;
    return -v;
  endfunction

  logic [DATA_WIDTH-1:0] quad;

  always_comb begin
    quad    = phase_i & MASK_W;
    flip_o  = (quad != '0) && (quad != MASK_W);
    angle_o = flip_o ? (phase_i ^ PI_W) : phase_i;
    x_o     = flip_i ? neg_sat(x_i) : x_i;
    y_o     = flip_i ? neg_sat(y_i) : y_i;
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// NCO sequencer around an iterative CORDIC: phase accumulate, fold, issue,
// unfold results. Optional CORDIC_WATCHDOG_EN adds a WAIT timeout and error_o.
module cordic_phase_sequencer
  import cordic_phase_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [DATA_WIDTH-1:0]        freq_word_i,
  cordic_phase_sequencer_if.master     cordic,
  output logic signed [DATA_WIDTH-1:0] cos_o,
  output logic signed [DATA_WIDTH-1:0] sin_o,
  output logic                         sample_valid_strobe_o,
  output logic                         busy_o
`ifdef CORDIC_WATCHDOG_EN
  ,
  output logic                         error_o
`endif
);

  if (DATA_WIDTH < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cordic_phase_sequencer: DATA_WIDTH must be >= 8 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]        phase_q, phase_d;
  logic [DATA_WIDTH-1:0]        z_q, z_d;
  logic                         zstb_q, zstb_d;
  logic                         flip_q, flip_d;
  logic signed [DATA_WIDTH-1:0] cos_q, cos_d;
  logic signed [DATA_WIDTH-1:0] sin_q, sin_d;
  logic                         svld_q, svld_d;
  logic                         busy_q, busy_d;

  logic [DATA_WIDTH-1:0]        fold_angle;
  logic                         fold_flip;
  logic signed [DATA_WIDTH-1:0] corr_cos, corr_sin;

`ifdef CORDIC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
`endif

  cordic_quadrant_fold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fold (
    .phase_i (phase_q),
    .angle_o (fold_angle),
    .flip_o  (fold_flip),
    .flip_i  (flip_q),
    .x_i     (cordic.cordic_x_i),
    .y_i     (cordic.cordic_y_i),
    .x_o     (corr_cos),
    .y_o     (corr_sin)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    z_d     = z_q;
    zstb_d  = 1'b0;
    flip_d  = flip_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    svld_d  = 1'b0;
`ifdef CORDIC_WATCHDOG_EN
    error_d = error_q;
    wd_d    = (state_q == WAIT) ? wd_q + 1'b1 : '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = ISSUE;
      end
      ISSUE: begin
        z_d     = fold_angle;
        flip_d  = fold_flip;
        zstb_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cordic.cordic_valid_strobe_i) begin
          cos_d   = corr_cos;
          sin_d   = corr_sin;
          svld_d  = 1'b1;
          phase_d = phase_q + freq_word_i;
          state_d = enable_i ? ISSUE : IDLE;
`ifdef CORDIC_WATCHDOG_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the conversion; phase and samples stay as they were.
          error_d = 1'b1;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      z_q     <= '0;
      zstb_q  <= 1'b0;
      flip_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      svld_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CORDIC_WATCHDOG_EN
      wd_q    <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      z_q     <= z_d;
      zstb_q  <= zstb_d;
      flip_q  <= flip_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      svld_q  <= svld_d;
      busy_q  <= busy_d;
`ifdef CORDIC_WATCHDOG_EN
      wd_q    <= wd_d;
      error_q <= error_d;
`endif
    end
  end

  assign cordic.cordic_z_o            = z_q;
  assign cordic.cordic_valid_strobe_o = zstb_q;
  assign cos_o                        = cos_q;
  assign sin_o                        = sin_q;
  assign sample_valid_strobe_o        = svld_q;
  assign busy_o                       = busy_q;
`ifdef CORDIC_WATCHDOG_EN
  assign error_o                      = error_q;
`endif

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Bench for cordic_phase_sequencer with a behavioural CORDIC responder and
// an NCO reference model; covers CORDIC_WATCHDOG_EN when that macro is set.
module tb_cordic_phase_sequencer;

  localparam int W       = 8;
  localparam int TIMEOUT = 31;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [W-1:0]      freq = '0;
  logic signed [W-1:0] cos_s, sin_s;
  logic              svld_s, busy_s;
`ifdef CORDIC_WATCHDOG_EN
  logic              error_s;
`endif

  cordic_phase_sequencer_if #(.DATA_WIDTH(W)) cif ();

  cordic_phase_sequencer #(
    .DATA_WIDTH(W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .enable_i              (enable),
    .freq_word_i           (freq),
    .cordic                (cif.master),
    .cos_o                 (cos_s),
    .sin_o                 (sin_s),
    .sample_valid_strobe_o (svld_s),
    .busy_o                (busy_s)
`ifdef CORDIC_WATCHDOG_EN
    ,
    .error_o               (error_s)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- CORDIC responder: y echoes the angle, x is programmable
  logic              resp_on = 1'b1;
  int                resp_lat = 3;
  logic signed [7:0] resp_x = 8'sd75;
  int                stray_cnt = 0;
  int                stray_done = 0;
  int                rcnt = 0;
  logic [7:0]        rz = '0;

  initial begin
    cif.cordic_valid_strobe_i = 1'b0;
    cif.cordic_x_i = '0;
    cif.cordic_y_i = '0;
    forever begin
      @(posedge clk); #1;
      cif.cordic_valid_strobe_i = 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        cif.cordic_valid_strobe_i = 1'b1;
        cif.cordic_x_i = 8'sd50;
        cif.cordic_y_i = 8'sd50;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          cif.cordic_valid_strobe_i = 1'b1;
          cif.cordic_x_i = resp_x;
          cif.cordic_y_i = rz;
        end
      end else if (cif.cordic_valid_strobe_o && resp_on) begin
        rz = cif.cordic_z_o;
        if (resp_lat == 0) begin
          cif.cordic_valid_strobe_i = 1'b1;
          cif.cordic_x_i = resp_x;
          cif.cordic_y_i = rz;
        end else begin
          rcnt = resp_lat;
        end
      end
    end
  end

  // ---------------- reference model
  function automatic logic [7:0] fold_angle(input int p);
    int s;
    s = (p >= 128) ? p - 256 : p;
    if (s >= -64 && s <= 63) return 8'(p);
    return 8'((p + 128) % 256);
  endfunction

  function automatic bit fold_flip(input int p);
    int s;
    s = (p >= 128) ? p - 256 : p;
    return !(s >= -64 && s <= 63);
  endfunction

  function automatic int neg_clip(input int v);
    return (v == -128) ? 127 : -v;
  endfunction

  logic              rst_e = 1'b1, done_e = 1'b0, en_e = 1'b0;
  logic [7:0]        freq_e = '0;
  logic signed [7:0] x_e = '0;

  always @(posedge clk) begin
    rst_e  <= rst;
    done_e <= cif.cordic_valid_strobe_i;
    en_e   <= enable;
    freq_e <= freq;
    x_e    <= cif.cordic_x_i;
  end

  int         mphase = 0;
  bit         waiting = 1'b0;
  bit         mflip = 1'b0;
  int         mz = 0;
  bit         exp_strobe = 1'b0;
  bit         merr = 1'b0;
  int         wait_cyc = 0;
  int         n_samples = 0;
  int         last_cos = 0, last_sin = 0;
  logic [7:0] z_log[$];

  always @(negedge clk) begin : cmp
    bit exp_svld;
    if (rst_e) begin
      chk("rst_cos", cos_s, 0);
      chk("rst_sin", sin_s, 0);
      chk("rst_svld", svld_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_z", cif.cordic_z_o, 0);
      chk("rst_zstb", cif.cordic_valid_strobe_o, 0);
`ifdef CORDIC_WATCHDOG_EN
      chk("rst_error", error_s, 0);
`endif
      mphase = 0; waiting = 0; exp_strobe = 0; merr = 0; wait_cyc = 0;
    end else begin
      exp_svld = done_e && waiting;
`ifdef CORDIC_WATCHDOG_EN
      if (waiting && !exp_svld && wait_cyc == TIMEOUT) begin
        waiting = 0;
        merr = 1;
        chk("wd_busy", busy_s, 0);
      end
      chk("wd_error", error_s, merr);
`endif
      if (exp_strobe) chk("strobe_after_sample", cif.cordic_valid_strobe_o, 1);
      exp_strobe = 0;
      chk("sample_strobe", svld_s, exp_svld);
      if (svld_s && exp_svld) begin
        chk("cos", cos_s, mflip ? neg_clip(int'(x_e)) : int'(x_e));
        chk("sin", sin_s, mflip ? neg_clip(mz) : mz);
        last_cos = int'(cos_s);
        last_sin = int'(sin_s);
        n_samples++;
        mphase = (mphase + int'(freq_e)) % 256;
        waiting = 0;
        if (en_e) exp_strobe = 1;
      end
      if (cif.cordic_valid_strobe_o) begin
        chk("single_strobe", waiting, 0);
        chk("z_fold", cif.cordic_z_o, fold_angle(mphase));
        mflip = fold_flip(mphase);
        mz = int'(signed'(fold_angle(mphase)));
        z_log.push_back(cif.cordic_z_o);
        waiting = 1;
        wait_cyc = 1;
      end else if (waiting) begin
        wait_cyc++;
      end
      if (waiting) chk("busy_wait", busy_s, 1);
    end
  end

  // ---------------- stimulus
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_strobes(input int target);
    int budget = 200;
    while (z_log.size() < target && budget > 0) begin step(1); budget--; end
    chk("wait_strobe", int'(z_log.size() >= target), 1);
  endtask

  task automatic wait_samples(input int target);
    int budget = 200;
    while (n_samples < target && budget > 0) begin step(1); budget--; end
    chk("wait_sample", int'(n_samples >= target), 1);
  endtask

  initial begin : stim
    int nz, ns;
    step(2);
    chk("init_cos", cos_s, 0);
    chk("init_busy", busy_s, 0);

    // basic stream, fold at 0x80, saturation at 0xA0
    rst = 0; freq = 8'h20; resp_lat = 3; resp_x = 8'sd75; enable = 1;
    wait_strobes(1);
    chk("first_z", z_log[0], 8'h00);
    wait_samples(1);
    chk("first_cos", last_cos, 75);
    chk("first_sin", last_sin, 0);
    wait_strobes(2);
    chk("second_z", z_log[1], 8'h20);
    wait_samples(4);
    chk("z_at_0x60", z_log[3], 8'hE0);
    chk("sin_at_0x60", last_sin, 32);
    wait_samples(5);
    chk("z_at_0x80", z_log[4], 8'h00);
    chk("cos_at_0x80", last_cos, -75);
    chk("sin_at_0x80", last_sin, 0);
    resp_x = -8'sd128;
    wait_samples(6);
    chk("sat_cos", last_cos, 127);
    chk("sat_sin", last_sin, -32);
    resp_x = 8'sd75;

    // enable dropped mid-WAIT: one more sample, then idle
    wait_strobes(7);
    enable = 0;
    step(10);
    chk("drop_samples", n_samples, 7);
    chk("drop_strobes", z_log.size(), 7);
    chk("drop_busy", busy_s, 0);

    // stray done strobe in IDLE
    stray_cnt++;
    step(4);
    chk("stray_samples", n_samples, 7);

    // phase wrap 0xF0 + 0x20 -> 0x10
    rst = 1; step(1); rst = 0;
    nz = z_log.size(); ns = n_samples;
    freq = 8'hF0; enable = 1;
    wait_samples(ns + 1);
    freq = 8'h20;
    wait_strobes(nz + 3);
    chk("wrap_z0", z_log[nz], 8'h00);
    chk("wrap_z1", z_log[nz + 1], 8'hF0);
    chk("wrap_z2", z_log[nz + 2], 8'h10);

    // reset pulsed in WAIT, late done ignored
    step(1);
    rst = 1; enable = 0;
    step(1);
    chk("rst_wait_cos", cos_s, 0);
    chk("rst_wait_busy", busy_s, 0);
    chk("rst_wait_z", cif.cordic_z_o, 0);
    rst = 0;
    step(6);
    chk("rst_wait_samples", n_samples, ns + 2);

    // done and enable fall on the same edge
    nz = z_log.size(); ns = n_samples;
    enable = 1;
    wait_strobes(nz + 1);
    step(2);
    enable = 0;
    step(8);
    chk("same_edge_samples", n_samples, ns + 1);
    chk("same_edge_strobes", z_log.size(), nz + 1);
    chk("same_edge_busy", busy_s, 0);

`ifdef CORDIC_WATCHDOG_EN
    // CORDIC never answers: timeout, sticky error, phase held
    rst = 1; step(1); rst = 0;
    nz = z_log.size(); ns = n_samples;
    resp_on = 0; enable = 1;
    wait_strobes(nz + 1);
    enable = 0;
    step(40);
    chk("wd_err_set", error_s, 1);
    chk("wd_idle", busy_s, 0);
    chk("wd_no_sample", n_samples, ns);
    resp_on = 1; enable = 1;
    wait_strobes(nz + 2);
    chk("wd_phase_held", z_log[nz + 1], 8'h00);
    wait_samples(ns + 1);
    enable = 0;
    chk("wd_err_sticky", error_s, 1);
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cordic_phase_sequencer.md
Name: cordic_phase_sequencer

Overview:
- Drives the iterative CORDIC core in rotation mode to produce a stream of cos/sin samples, i.e. an NCO front/back end.
- Upstream side: holds an 8-bit phase accumulator, folds each phase into the CORDIC convergence range and issues it as an angle with a one-cycle strobe.
- Downstream side: waits for the core's done strobe, undoes the quadrant fold on the results and presents registered samples with a valid strobe.
- Sits between the tile top level (switch/IO inputs) and cordic_iterative.

Parameters:
- DATA_WIDTH, 8, width of phase, angle and sample words.
- TIMEOUT_CYCLES, 31, cycles to wait for the CORDIC done strobe before aborting (only used with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  level; while high, samples are generated back-to-back.
- freq_word_i  in  DATA_WIDTH  phase increment per sample (256 = 2*pi).
- cordic_z_o  out  DATA_WIDTH  angle to CORDIC z input, signed binary angle (128 = pi).
- cordic_valid_strobe_o  out  1  one-cycle start strobe to the CORDIC.
- cordic_x_i  in  DATA_WIDTH  CORDIC x result (cos, signed).
- cordic_y_i  in  DATA_WIDTH  CORDIC y result (sin, signed).
- cordic_valid_strobe_i  in  1  CORDIC done strobe.
- cos_o  out  DATA_WIDTH  corrected cos sample, signed.
- sin_o  out  DATA_WIDTH  corrected sin sample, signed.
- sample_valid_strobe_o  out  1  one-cycle pulse when cos_o/sin_o update.
- busy_o  out  1  high in ISSUE or WAIT.

Behaviour:
- Reset: phase=0, cordic_z_o=0, cordic_valid_strobe_o=0, cos_o=0, sin_o=0, sample_valid_strobe_o=0, busy_o=0, flip=0; FSM goes to IDLE.
- Reset mid-operation aborts any pending conversion. A later stray cordic_valid_strobe_i is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if enable_i, go to ISSUE.
  - ISSUE, 1 cycle:
    - Phase p is treated as signed.
    - If p[7:6] is 00 or 11 (p in [-64,63]): cordic_z_o=p, flip=0.
    - Otherwise: cordic_z_o=p^0x80 (p+pi mod 2pi), flip=1.
    - Assert cordic_valid_strobe_o for exactly this cycle, then go to WAIT.
  - WAIT: on cordic_valid_strobe_i, on the next edge:
    - Register cos_o/sin_o.
    - Pulse sample_valid_strobe_o for one cycle.
    - Update phase <= phase + freq_word_i, mod 256 with wrap and no flag.
    - Go to ISSUE if enable_i is high, else IDLE.
- Correction when flip=1: cos_o=-x and sin_o=-y, using two's-complement negation.
  - Saturation: -(-128) gives +127.
  - When flip=0, outputs pass through unchanged.
- Latency: ISSUE-to-sample time is the CORDIC latency + 1 cycle. Sample period is the CORDIC latency + 2 cycles.
- cordic_valid_strobe_i in IDLE or ISSUE is ignored.
- Strobe-in and enable_i falling in the same cycle: the current sample completes and the FSM returns to IDLE.
- freq_word_i is sampled only at the phase update edge; changes mid-conversion affect the next sample only.
- cos_o/sin_o hold their last value between strobes.

Optional Feature:
- Macro: CORDIC_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without cordic_valid_strobe_i, the FSM returns to IDLE, sets a sticky error_o (extra 1-bit output port), and leaves phase and outputs unchanged with no sample strobe.
  - error_o is cleared only by rst_i.
- Undefined: no counter, no error_o port, and WAIT lasts indefinitely.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE/ISSUE/WAIT).
  - Angle constants: ANGLE_PI=8'h80 and the quadrant-fold mask.
  - Sample saturation limits SAMPLE_MAX=127 and SAMPLE_MIN=-128.
- One natural sub-module, cordic_quadrant_fold: combinational fold of phase to angle and flip. It is reused for the negate/saturate correction on both result channels.

Test Plan:
- Basic sample: reset, freq_word=0x20, enable=1; CORDIC model returns x=75, y=0 for z=0.
  - Required: first cordic_z_o=0x00 with a single strobe, cos_o=75, sin_o=0, one sample strobe, then next cordic_z_o=0x20.
- Fold: phase reaches 0x80.
  - Required: cordic_z_o=0x00, flip=1; with model x=75, y=0 the outputs are cos_o=-75 (0xB5) and sin_o=0.
- Saturation: flip=1 and model returns x=-128.
  - Required: cos_o=127.
- Wrap: phase=0xF0, freq_word=0x20.
  - Required: next phase 0x10, which folds to z=0x10, flip=0.
- Handshake edges:
  - Stray cordic_valid_strobe_i in IDLE produces no sample strobe.
  - Dropping enable_i during WAIT still yields exactly one more sample, then busy_o=0.
  - rst_i pulsed in WAIT returns all outputs to 0 the next cycle.
- With CORDIC_WATCHDOG_EN: the model never responds.
  - Required: after 31 WAIT cycles the FSM is in IDLE, error_o=1, no sample strobe, and phase is unchanged.
